// File: rtl/alu_pkg.sv
// Shared ALU selection codes, FSM state encoding and shift helpers for the
// execute-stage ALU and the upstream ALU control decoder.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLLI = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_SRLI = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SRAI = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;

  typedef enum logic [1:0] {
    SH_NONE,
    SH_LEFT,
    SH_RIGHT,
    SH_ARITH
  } shift_kind_t;

  function automatic shift_kind_t shiftKind(input logic [3:0] sel);
    shift_kind_t kind;
    case (sel)
      ALU_SLL, ALU_SLLI: kind = SH_LEFT;
      ALU_SRL, ALU_SRLI: kind = SH_RIGHT;
      ALU_SRA, ALU_SRAI: kind = SH_ARITH;
      default:           kind = SH_NONE;
    endcase
    return kind;
  endfunction

  // One step of the iterative shifter; arithmetic right replicates the sign bit.
  function automatic logic [XLEN-1:0] shiftOnce(input shift_kind_t kind,
                                                input logic [XLEN-1:0] value);
    logic [XLEN-1:0] r;
    case (kind)
      SH_LEFT:  r = {value[XLEN-2:0], 1'b0};
      SH_RIGHT: r = {1'b0, value[XLEN-1:1]};
      SH_ARITH: r = {value[XLEN-1], value[XLEN-1:1]};
      default:  r = value;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Purely combinational single-cycle datapath: add/sub, logic, compares and flags.
// Shift codes pass op A through, which is the correct result for a zero shift amount.
module alu_comb
  import alu_pkg::*;
(
  input  logic [3:0]      aluSel_i,
  input  logic [XLEN-1:0] opA_i,
  input  logic [XLEN-1:0] opB_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            lt_o,
  output logic            ltu_o
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  assign sum   = opA_i + opB_i;
  assign diff  = opA_i - opB_i;
  assign lt_o  = $signed(opA_i) < $signed(opB_i);
  assign ltu_o = opA_i < opB_i;

  always_comb begin
    result_o = sum;
    case (aluSel_i)
      ALU_ADD:  result_o = sum;
      ALU_SUB:  result_o = diff;
      ALU_OR:   result_o = opA_i | opB_i;
      ALU_AND:  result_o = opA_i & opB_i;
      ALU_XOR:  result_o = opA_i ^ opB_i;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_o};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, ltu_o};
      ALU_SLL, ALU_SLLI, ALU_SRL, ALU_SRLI, ALU_SRA, ALU_SRAI:
                result_o = opA_i;
      default:  result_o = sum;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops via alu_comb, shifts on an iterative
// 1-bit-per-cycle shifter, valid/ready handshake on both sides.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            inValid_i,
  output logic            inReady_o,
  input  logic [3:0]      aluSel_i,
  input  logic [XLEN-1:0] opA_i,
  input  logic [XLEN-1:0] opB_i,
  output logic            outValid_o,
  input  logic            outReady_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            lt_o,
  output logic            ltu_o,
  output logic            busy_o
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [4:0]      count_q, count_d;
  shift_kind_t     kind_q, kind_d;
  logic            ltHold_q, ltHold_d;
  logic            ltuHold_q, ltuHold_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            lt_q, lt_d;
  logic            ltu_q, ltu_d;

  logic [XLEN-1:0] combResult;
  logic            combZero, combLt, combLtu;
  logic [XLEN-1:0] shifted;
  logic            accept;
  shift_kind_t     selKind;
  logic [4:0]      shamt;

  alu_comb uComb (
    .aluSel_i (aluSel_i),
    .opA_i    (opA_i),
    .opB_i    (opB_i),
    .result_o (combResult),
    .zero_o   (combZero),
    .lt_o     (combLt),
    .ltu_o    (combLtu)
  );

  assign inReady_o = !reset_i && !flush_i &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && outReady_i));
  assign accept    = inValid_i && inReady_o;
  assign selKind   = shiftKind(aluSel_i);
  assign shamt     = opB_i[4:0];
  assign shifted   = shiftOnce(kind_q, work_q);

  // Compare flags of a shift are latched at accept and published with the final result.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    count_d   = count_q;
    kind_d    = kind_q;
    ltHold_d  = ltHold_q;
    ltuHold_d = ltuHold_q;
    result_d  = result_q;
    zero_d    = zero_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;

    if (flush_i) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          work_d  = shifted;
          count_d = count_q - 5'd1;
          if (count_q == 5'd1) begin
            result_d = shifted;
            zero_d   = (shifted == '0);
            lt_d     = ltHold_q;
            ltu_d    = ltuHold_q;
            state_d  = ST_HOLD;
          end
        end
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if ((selKind != SH_NONE) && (shamt != 5'd0)) begin
              work_d    = opA_i;
              count_d   = shamt;
              kind_d    = selKind;
              ltHold_d  = combLt;
              ltuHold_d = combLtu;
              state_d   = ST_SHIFT;
            end else begin
              result_d = combResult;
              zero_d   = combZero;
              lt_d     = combLt;
              ltu_d    = combLtu;
              state_d  = ST_HOLD;
            end
          end else if ((state_q == ST_HOLD) && outReady_i) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      count_q   <= '0;
      kind_q    <= SH_NONE;
      ltHold_q  <= 1'b0;
      ltuHold_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      count_q   <= count_d;
      kind_q    <= kind_d;
      ltHold_q  <= ltHold_d;
      ltuHold_q <= ltuHold_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
    end
  end

  assign outValid_o = (state_q == ST_HOLD);
  assign busy_o     = (state_q == ST_SHIFT);
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign lt_o       = lt_q;
  assign ltu_o      = ltu_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued at accept and
// popped by an independent monitor whenever an output transfer happens.
module tb_alu_exec_unit;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        ltu;
  } expect_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [3:0]  aluSel;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        zero;
  logic        lt;
  logic        ltu;
  logic        busy;

  int      totalCount = 0;
  int      badCount = 0;
  bit      randomReady = 1'b0;
  expect_t expQ[$];
  expect_t monExp;

  alu_exec_unit dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .flush_i    (flush),
    .inValid_i  (inValid),
    .inReady_o  (inReady),
    .aluSel_i   (aluSel),
    .opA_i      (opA),
    .opB_i      (opB),
    .outValid_o (outValid),
    .outReady_i (outReady),
    .result_o   (result),
    .zero_o     (zero),
    .lt_o       (lt),
    .ltu_o      (ltu),
    .busy_o     (busy)
  );

  always #5 clock = ~clock;

  // Reference behaviour straight from the operation table, using native operators.
  function automatic expect_t refModel(input logic [3:0] sel, input logic [31:0] a,
                                       input logic [31:0] b);
    expect_t e;
    int      sh;
    sh = int'(b[4:0]);
    case (sel)
      4'b0001:          e.res = a - b;
      4'b0100:          e.res = a | b;
      4'b0101:          e.res = a & b;
      4'b0111:          e.res = a ^ b;
      4'b1101:          e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1111:          e.res = (a < b) ? 32'd1 : 32'd0;
      4'b1000, 4'b0010: e.res = a << sh;
      4'b1001, 4'b0110: e.res = a >> sh;
      4'b1010, 4'b1011: e.res = $unsigned($signed(a) >>> sh);
      default:          e.res = a + b;
    endcase
    e.z   = (e.res == 32'd0);
    e.lt  = $signed(a) < $signed(b);
    e.ltu = a < b;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one operation and holds it until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input bit expectOut,
                               output int waits);
    bit done;
    aluSel  = sel;
    opA     = a;
    opB     = b;
    inValid = 1'b1;
    waits   = 0;
    done    = 1'b0;
    while (!done && waits < 200) begin
      if (randomReady) outReady = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (inReady) begin
        if (expectOut) expQ.push_back(refModel(sel, a, b));
        done = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    inValid = 1'b0;
    if (!done) begin
      totalCount++;
      badCount++;
      $display("[TB] FAIL acceptTimeout: got no accept in %0d cycles, required accept", waits);
    end
  endtask

  task automatic measureLatency(output int latency, output int stalls);
    latency = 1;
    stalls  = 0;
    while (!outValid && latency < 100) begin
      if (!inReady) stalls++;
      tick();
      latency++;
    end
  endtask

  always @(negedge clock) begin
    if (outValid && outReady) begin
      totalCount++;
      if (expQ.size() == 0) begin
        badCount++;
        $display("[TB] FAIL unexpectedOutput: got result 0x%08h, required no output", result);
      end else begin
        monExp = expQ.pop_front();
        if ({result, zero, lt, ltu} !== {monExp.res, monExp.z, monExp.lt, monExp.ltu}) begin
          badCount++;
          $display("[TB] FAIL scoreboard: got res=0x%08h z=%b lt=%b ltu=%b, required res=0x%08h z=%b lt=%b ltu=%b",
                   result, zero, lt, ltu, monExp.res, monExp.z, monExp.lt, monExp.ltu);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          waits;
    int          latency;
    int          stalls;
    expect_t     e;
    logic [3:0]  rSel;
    logic [31:0] rA;
    logic [31:0] rB;

    reset    = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    aluSel   = 4'd0;
    opA      = 32'd0;
    opB      = 32'd0;
    outReady = 1'b1;

    repeat (2) begin
      @(negedge clock);
      checkBit("resetInReady", inReady, 1'b0);
      checkBit("resetOutValid", outValid, 1'b0);
      checkOutput("resetResult", result, 32'd0);
    end
    tick();
    reset = 1'b0;
    #1;
    checkBit("inReadyAfterReset", inReady, 1'b1);

    applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, waits);
    checkOutput("addWaits", waits, 0);
    checkBit("addLatency1", outValid, 1'b1);
    checkOutput("addResult", result, 32'h8000_0000);
    applyStimulus(ALU_SUB, 32'd5, 32'd5, 1'b1, waits);
    checkOutput("subBackToBack", waits, 0);
    checkOutput("subResult", result, 32'd0);
    checkBit("subZero", zero, 1'b1);

    applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, waits);
    checkOutput("sltResult", result, 32'd1);
    checkBit("sltFlag", lt, 1'b1);
    applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1, waits);
    checkOutput("sltuResult", result, 32'd0);
    checkBit("sltuFlag", ltu, 1'b0);

    applyStimulus(ALU_SRA, 32'h8000_0000, 32'd4, 1'b1, waits);
    measureLatency(latency, stalls);
    checkOutput("sraLatency", latency, 5);
    checkOutput("sraStalls", stalls, 4);
    checkOutput("sraResult", result, 32'hF800_0000);

    applyStimulus(ALU_SRLI, 32'h8000_0000, 32'd31, 1'b1, waits);
    measureLatency(latency, stalls);
    checkOutput("srliLatency", latency, 32);
    checkOutput("srliResult", result, 32'h0000_0001);

    applyStimulus(ALU_SLL, 32'h8000_0000, 32'd0, 1'b1, waits);
    measureLatency(latency, stalls);
    checkOutput("sll0Latency", latency, 1);
    checkOutput("sll0Result", result, 32'h8000_0000);
    tick();

    // Back-pressure: the held result must stay put and no new op may enter.
    outReady = 1'b0;
    applyStimulus(ALU_ADD, 32'h1234_5678, 32'h1111_1111, 1'b1, waits);
    e = refModel(ALU_ADD, 32'h1234_5678, 32'h1111_1111);
    repeat (3) begin
      @(negedge clock);
      checkOutput("frozenResult", result, e.res);
      checkBit("frozenLt", lt, e.lt);
      checkBit("frozenOutValid", outValid, 1'b1);
      checkBit("frozenInReady", inReady, 1'b0);
    end
    tick();
    outReady = 1'b1;
    applyStimulus(ALU_ADD, 32'd1, 32'd2, 1'b1, waits);
    checkOutput("releaseSameCycle", waits, 0);

    applyStimulus(ALU_SLL, 32'd1, 32'd20, 1'b0, waits);
    repeat (3) tick();
    checkBit("busyMidShift", busy, 1'b1);
    tick();
    flush   = 1'b1;
    inValid = 1'b1;
    aluSel  = ALU_ADD;
    opA     = 32'd9;
    opB     = 32'd9;
    @(negedge clock);
    checkBit("flushInReady", inReady, 1'b0);
    tick();
    flush   = 1'b0;
    inValid = 1'b0;
    checkBit("flushOutValid", outValid, 1'b0);
    checkBit("flushBusy", busy, 1'b0);
    applyStimulus(ALU_ADD, 32'd3, 32'd4, 1'b1, waits);
    checkOutput("afterFlushWaits", waits, 0);

    applyStimulus(ALU_SLL, 32'd1, 32'd20, 1'b0, waits);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checkBit("rstOutValid", outValid, 1'b0);
    checkOutput("rstResult", result, 32'd0);
    checkBit("rstZero", zero, 1'b0);
    checkBit("rstLt", lt, 1'b0);
    checkBit("rstLtu", ltu, 1'b0);
    checkBit("rstBusy", busy, 1'b0);
    checkBit("rstInReady", inReady, 1'b0);
    reset = 1'b0;
    #1;
    checkBit("rstReleaseInReady", inReady, 1'b1);

    randomReady = 1'b1;
    for (int i = 0; i < 80; i++) begin
      rSel = 4'($urandom_range(0, 15));
      rA   = $urandom;
      rB   = ($urandom_range(0, 3) == 0) ? rA : $urandom;
      applyStimulus(rSel, rA, rB, 1'b1, waits);
    end
    randomReady = 1'b0;
    outReady    = 1'b1;
    for (int i = 0; i < 100 && expQ.size() != 0; i++) tick();
    checkOutput("drainQueue", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
